// File: rtl/stopwatch_timebase_ctrl.sv
// rtl/stopwatch_timebase_ctrl.sv - run/hold/clear sequencer and mm:ss.hh cascade for the stopwatch timebase
// Optional lap capture registers are built when STOPWATCH_LAP_EN is defined.
module stopwatch_timebase_ctrl #(
    parameter int PRE_DIV = 3,
    parameter int MIN_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
    output logic [6:0] lap_hund,
    output logic [5:0] lap_sec,
    output logic [5:0] lap_min,
    output logic       lap_valid,
`endif
    output logic       running,
    output logic [3:0] pre_cnt,
    output logic [6:0] hund,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic       sec_tick,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] PRE_LAST = 4'(PRE_DIV - 1);
    localparam logic [5:0] MIN_LAST = 6'(MIN_MAX);

    state_t     state_q, state_d;
    logic       running_q, running_d;
    logic [3:0] pre_q, pre_d;
    logic [6:0] hund_q, hund_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       sec_tick_q, sec_tick_d;
    logic       ovf_q, ovf_d;

    logic count_en;
    logic hund_carry;
    logic sec_carry;
    logic min_carry;

    // The tick is judged against the current state, so a stop in the same
    // cycle still counts and a start from IDLE/HOLD does not.
    assign count_en   = (state_q == RUN) && tick_in && !clear;
    assign hund_carry = count_en && (pre_q == PRE_LAST);
    assign sec_carry  = hund_carry && (hund_q == 7'd99);
    assign min_carry  = sec_carry && (sec_q == 6'd59);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            running_q  <= 1'b0;
            pre_q      <= 4'd0;
            hund_q     <= 7'd0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            sec_tick_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= running_d;
            pre_q      <= pre_d;
            hund_q     <= hund_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            sec_tick_q <= sec_tick_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (stop)  state_d = HOLD;
                HOLD:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign running_d = (state_d == RUN);

    always_comb begin
        pre_d      = pre_q;
        hund_d     = hund_q;
        sec_d      = sec_q;
        min_d      = min_q;
        sec_tick_d = 1'b0;
        ovf_d      = 1'b0;
        if (clear) begin
            pre_d  = 4'd0;
            hund_d = 7'd0;
            sec_d  = 6'd0;
            min_d  = 6'd0;
        end else if (count_en) begin
            pre_d = hund_carry ? 4'd0 : pre_q + 4'd1;
            if (hund_carry) begin
                hund_d = sec_carry ? 7'd0 : hund_q + 7'd1;
            end
            if (sec_carry) begin
                sec_d      = min_carry ? 6'd0 : sec_q + 6'd1;
                sec_tick_d = 1'b1;
            end
            if (min_carry) begin
                min_d = (min_q == MIN_LAST) ? 6'd0 : min_q + 6'd1;
                ovf_d = (min_q == MIN_LAST);
            end
        end
    end

    assign running  = running_q;
    assign pre_cnt  = pre_q;
    assign hund     = hund_q;
    assign sec      = sec_q;
    assign min      = min_q;
    assign sec_tick = sec_tick_q;
    assign ovf      = ovf_q;

`ifdef STOPWATCH_LAP_EN
    logic [6:0] lap_hund_q, lap_hund_d;
    logic [5:0] lap_sec_q, lap_sec_d;
    logic [5:0] lap_min_q, lap_min_d;
    logic       lap_valid_q, lap_valid_d;

    // Captures the value on display before this cycle's increment lands.
    always_comb begin
        lap_hund_d  = lap_hund_q;
        lap_sec_d   = lap_sec_q;
        lap_min_d   = lap_min_q;
        lap_valid_d = lap_valid_q;
        if (clear) begin
            lap_hund_d  = 7'd0;
            lap_sec_d   = 6'd0;
            lap_min_d   = 6'd0;
            lap_valid_d = 1'b0;
        end else if (lap && (state_q == RUN)) begin
            lap_hund_d  = hund_q;
            lap_sec_d   = sec_q;
            lap_min_d   = min_q;
            lap_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_hund_q  <= 7'd0;
            lap_sec_q   <= 6'd0;
            lap_min_q   <= 6'd0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_hund_q  <= lap_hund_d;
            lap_sec_q   <= lap_sec_d;
            lap_min_q   <= lap_min_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_hund  = lap_hund_q;
    assign lap_sec   = lap_sec_q;
    assign lap_min   = lap_min_q;
    assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_stopwatch_timebase_ctrl.sv
// tb/tb_stopwatch_timebase_ctrl.sv - self-checking bench for stopwatch_timebase_ctrl
module tb_stopwatch_timebase_ctrl;

    localparam int PRE_DIV = 3;
    localparam int MIN_MAX = 1;
    localparam int PERIOD  = 100 * 60 * (MIN_MAX + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       running;
    logic [3:0] pre_cnt;
    logic [6:0] hund;
    logic [5:0] sec;
    logic [5:0] min;
    logic       sec_tick;
    logic       ovf;
`ifdef STOPWATCH_LAP_EN
    logic       lap = 1'b0;
    logic [6:0] lap_hund;
    logic [5:0] lap_sec;
    logic [5:0] lap_min;
    logic       lap_valid;
`endif

    int n_checks = 0;
    int n_fail = 0;

    stopwatch_timebase_ctrl #(.PRE_DIV(PRE_DIV), .MIN_MAX(MIN_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
`ifdef STOPWATCH_LAP_EN
        .lap      (lap),
        .lap_hund (lap_hund),
        .lap_sec  (lap_sec),
        .lap_min  (lap_min),
        .lap_valid(lap_valid),
`endif
        .running  (running),
        .pre_cnt  (pre_cnt),
        .hund     (hund),
        .sec      (sec),
        .min      (min),
        .sec_tick (sec_tick),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Model: elapsed time held as one hundredths total, display fields derived by division.
    int m_mode = 0;  // 0 idle, 1 run, 2 hold
    int m_pre = 0;
    int m_total = 0;
    int m_stick = 0;
    int m_ovf = 0;
`ifdef STOPWATCH_LAP_EN
    int m_lap_total = 0;
    int m_lap_valid = 0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pre = 0; m_total = 0; m_stick = 0; m_ovf = 0;
`ifdef STOPWATCH_LAP_EN
            m_lap_total = 0; m_lap_valid = 0;
`endif
        end else begin
            m_stick = 0;
            m_ovf = 0;
            if (clear) begin
                m_mode = 0; m_pre = 0; m_total = 0;
`ifdef STOPWATCH_LAP_EN
                m_lap_total = 0; m_lap_valid = 0;
`endif
            end else begin
`ifdef STOPWATCH_LAP_EN
                if (m_mode == 1 && lap) begin
                    m_lap_total = m_total;
                    m_lap_valid = 1;
                end
`endif
                if (m_mode == 1 && tick_in) begin
                    m_pre = m_pre + 1;
                    if (m_pre == PRE_DIV) begin
                        m_pre = 0;
                        if (m_total % 100 == 99) m_stick = 1;
                        m_total = (m_total + 1) % PERIOD;
                        if (m_total == 0) m_ovf = 1;
                    end
                end
                if (stop && m_mode == 1) m_mode = 2;
                else if (start && m_mode != 1) m_mode = 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_running", int'(running), (m_mode == 1) ? 1 : 0);
        chk("cmp_pre_cnt", int'(pre_cnt), m_pre);
        chk("cmp_hund", int'(hund), m_total % 100);
        chk("cmp_sec", int'(sec), (m_total / 100) % 60);
        chk("cmp_min", int'(min), m_total / 6000);
        chk("cmp_sec_tick", int'(sec_tick), m_stick);
        chk("cmp_ovf", int'(ovf), m_ovf);
`ifdef STOPWATCH_LAP_EN
        chk("cmp_lap_hund", int'(lap_hund), m_lap_total % 100);
        chk("cmp_lap_sec", int'(lap_sec), (m_lap_total / 100) % 60);
        chk("cmp_lap_min", int'(lap_min), m_lap_total / 6000);
        chk("cmp_lap_valid", int'(lap_valid), m_lap_valid);
`endif
    end

    task automatic cyc(input logic t, input logic s, input logic p, input logic c);
        tick_in = t; start = s; stop = p; clear = c;
        @(posedge clk);
        #1;
        tick_in = 0; start = 0; stop = 0; clear = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    task automatic chk_time(input string name, input int m, input int s, input int h);
        chk({name, "_min"}, int'(min), m);
        chk({name, "_sec"}, int'(sec), s);
        chk({name, "_hund"}, int'(hund), h);
    endtask

    initial begin
        #12;
        chk("rst_running", int'(running), 0);
        chk("rst_pre", int'(pre_cnt), 0);
        chk_time("rst", 0, 0, 0);
        chk("rst_sec_tick", int'(sec_tick), 0);
        chk("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        cyc(0, 1, 0, 0);
        chk("start_running", int'(running), 1);
        cyc(1, 0, 0, 0); chk("pre_1", int'(pre_cnt), 1); chk("hund_0", int'(hund), 0);
        cyc(1, 0, 0, 0); chk("pre_2", int'(pre_cnt), 2);
        cyc(1, 0, 0, 0); chk("pre_0", int'(pre_cnt), 0); chk("hund_1", int'(hund), 1);

        ticks(5998 * 3);
        chk_time("t0059_99", 0, 59, 99);
        ticks(2);
        chk("pre_sec_tick_lo", int'(sec_tick), 0);
        ticks(1);
        chk_time("t0100_00", 1, 0, 0);
        chk("sec_tick_hi", int'(sec_tick), 1);
        cyc(0, 0, 0, 0);
        chk("sec_tick_once", int'(sec_tick), 0);

        ticks(5999 * 3);
        chk_time("t0159_99", 1, 59, 99);
        chk("ovf_lo", int'(ovf), 0);
        ticks(3);
        chk_time("wrap", 0, 0, 0);
        chk("ovf_hi", int'(ovf), 1);
        ticks(1);
        chk("ovf_once", int'(ovf), 0);
        chk("count_after_wrap", int'(pre_cnt), 1);

        ticks(16);
        chk("hund_5", int'(hund), 5);
        chk("pre_at_2", int'(pre_cnt), 2);
        cyc(1, 0, 1, 0);
        chk("stop_tick_hund", int'(hund), 6);
        chk("stop_tick_pre", int'(pre_cnt), 0);
        chk("hold_running", int'(running), 0);
        ticks(4);
        chk("hold_hund", int'(hund), 6);
        chk("hold_pre", int'(pre_cnt), 0);
        cyc(0, 1, 0, 0);
        chk("resume_running", int'(running), 1);
        cyc(1, 0, 0, 0);
        chk("resume_pre", int'(pre_cnt), 1);
        chk("resume_hund", int'(hund), 6);
        cyc(0, 0, 1, 0);
        cyc(1, 1, 0, 0);
        chk("start_tick_ignored", int'(pre_cnt), 1);
        cyc(0, 0, 1, 0);
        cyc(1, 1, 0, 1);
        chk("clear_start_running", int'(running), 0);
        chk("clear_start_pre", int'(pre_cnt), 0);
        chk_time("clear_start", 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
        cyc(0, 1, 0, 0);
        ticks(237 * 3);
        chk_time("t0002_37", 0, 2, 37);
        lap = 1;
        cyc(1, 0, 0, 0);
        lap = 0;
        chk("lap_sec", int'(lap_sec), 2);
        chk("lap_hund", int'(lap_hund), 37);
        chk("lap_valid", int'(lap_valid), 1);
        ticks(2);
        chk("live_hund", int'(hund), 38);
        chk("lap_hold", int'(lap_hund), 37);
        cyc(0, 0, 0, 1);
        chk("lap_clr_hund", int'(lap_hund), 0);
        chk("lap_clr_sec", int'(lap_sec), 0);
        chk("lap_clr_valid", int'(lap_valid), 0);
`endif

        cyc(0, 1, 0, 0);
        ticks(10);
        chk("pre_async", int'(hund), 3);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("async_running", int'(running), 0);
        chk("async_pre", int'(pre_cnt), 0);
        chk_time("async", 0, 0, 0);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        chk("post_rst_running", int'(running), 0);
        cyc(0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
